fc_classifier_top: RTL and testbench

//  Top of the INT8 digit-classifier datapath: one fully-connected layer with 96 inputs and 10 outputs.

---
 rtl/fc_classifier_top_if.sv | 37 +++
 rtl/fc_classifier_top.sv | 239 +++++++++++++++++++++++
 tb/tb_fc_classifier_top.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_classifier_top_if.sv
// Handshake bundle for fc_classifier_top: input-memory write port, start, and result.
// FC_SCORE_OUT_EN adds the winning-score signal to both modports.
interface fc_classifier_top_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int WR_DATA_WIDTH = 128,
  parameter int NUM_WIDTH     = 4
`ifdef FC_SCORE_OUT_EN
  , parameter int SCORE_WIDTH = 24
`endif
);
  logic                     we;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [NUM_WIDTH-1:0]     number;
`ifdef FC_SCORE_OUT_EN
  logic signed [SCORE_WIDTH-1:0] score;
`endif

  modport master (
    output we, wr_addr, wr_data, start,
    input  busy, done, number
`ifdef FC_SCORE_OUT_EN
    , input score
`endif
  );

  modport slave (
    input  we, wr_addr, wr_data, start,
    output busy, done, number
`ifdef FC_SCORE_OUT_EN
    , output score
`endif
  );
endinterface

// File: rtl/fc_classifier_top.sv
// INT8 fully-connected layer (96 inputs, 10 classes) on a 2x16 MAC array followed by argmax.
// Optional macro FC_SCORE_OUT_EN exposes the winning score next to number.
module fc_mem #(
  parameter int DW = 128,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

module fc_classifier_top #(
  parameter int DATA_WIDTH          = 8,
  parameter int PE_OUT_WIDTH        = 24,
  parameter int ARRAY_M             = 2,
  parameter int ARRAY_N             = 16,
  parameter int INP_MEM_DATA_WIDTH  = 128,
  parameter int WGT_MEM_DATA_WIDTH  = 128,
  parameter int BIAS_MEM_DATA_WIDTH = 80,
  parameter int INP_CHANNEL         = 96,
  parameter int WGT_CHANNEL         = 96,
  parameter int ADDR_WIDTH          = 10,
  parameter int OUTPUT_CHANNEL      = 10
) (
  input logic                clk,
  input logic                reset_n,
  fc_classifier_top_if.slave bus
);
  localparam int BEATS  = INP_CHANNEL / ARRAY_N;
  localparam int WBEATS = WGT_CHANNEL / ARRAY_N;
  localparam int PASSES = OUTPUT_CHANNEL / ARRAY_M;
  localparam int NUM_W  = $clog2(OUTPUT_CHANNEL);
  localparam int PH_W   = $clog2(BEATS + 2);
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  // IDLE: wait for start | RUN: passes of address/drain/store | ARGMAX: scan scores | DONE: result pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARGMAX, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [NUM_W-1:0]    aidx_q, aidx_d;
  logic                busy, done;

  logic                              vld_q;
  logic signed [PE_OUT_WIDTH-1:0]    acc_q   [ARRAY_M];
  logic signed [PE_OUT_WIDTH-1:0]    score_q [OUTPUT_CHANNEL];
  logic signed [PE_OUT_WIDTH-1:0]    best_val_q;
  logic [NUM_W-1:0]                  best_idx_q;
  logic [NUM_W-1:0]                  number_q;

  logic [ADDR_WIDTH-1:0]             inp_addr, wgt_addr;
  logic [INP_MEM_DATA_WIDTH-1:0]     inp_rd;
  logic [WGT_MEM_DATA_WIDTH-1:0]     wgt_rd [ARRAY_M];
  logic [BIAS_MEM_DATA_WIDTH-1:0]    bias_rd;
  logic                              inp_we;

  logic signed [DATA_WIDTH-1:0]      inp_lane [ARRAY_N];
  logic signed [DATA_WIDTH-1:0]      wgt_lane [ARRAY_M][ARRAY_N];
  logic signed [PROD_W-1:0]          prod     [ARRAY_M][ARRAY_N];
  logic signed [PE_OUT_WIDTH-1:0]    dot_sum  [ARRAY_M];
  logic signed [DATA_WIDTH-1:0]      bias_ch  [OUTPUT_CHANNEL];
  logic [NUM_W-1:0]                  st_idx   [ARRAY_M];
  logic [NUM_W-1:0]                  win_idx;
  logic signed [PE_OUT_WIDTH-1:0]    win_val;
  logic                              store_cyc;

  // Input writes are only honoured while idle so a running inference sees stable data.
  assign inp_we   = bus.we && (state_q == S_IDLE);
  assign inp_addr = ADDR_WIDTH'(phase_q);
  assign wgt_addr = ADDR_WIDTH'(int'(pass_q) * WBEATS + int'(phase_q));

  fc_mem #(.DW(INP_MEM_DATA_WIDTH), .AW(ADDR_WIDTH)) inp_mem (
    .clk(clk), .we_i(inp_we), .wr_addr_i(bus.wr_addr), .wr_data_i(bus.wr_data),
    .rd_addr_i(inp_addr), .rd_data_o(inp_rd)
  );

  fc_mem #(.DW(WGT_MEM_DATA_WIDTH), .AW(ADDR_WIDTH)) wgt_mem1 (
    .clk(clk), .we_i(1'b0), .wr_addr_i('0), .wr_data_i('0),
    .rd_addr_i(wgt_addr), .rd_data_o(wgt_rd[0])
  );

  fc_mem #(.DW(WGT_MEM_DATA_WIDTH), .AW(ADDR_WIDTH)) wgt_mem2 (
    .clk(clk), .we_i(1'b0), .wr_addr_i('0), .wr_data_i('0),
    .rd_addr_i(wgt_addr), .rd_data_o(wgt_rd[1])
  );

  fc_mem #(.DW(BIAS_MEM_DATA_WIDTH), .AW(ADDR_WIDTH)) bias_mem (
    .clk(clk), .we_i(1'b0), .wr_addr_i('0), .wr_data_i('0),
    .rd_addr_i('0), .rd_data_o(bias_rd)
  );

  for (genvar k = 0; k < ARRAY_N; k++) begin : g_lane
    assign inp_lane[k] = inp_rd[k*DATA_WIDTH +: DATA_WIDTH];
    for (genvar r = 0; r < ARRAY_M; r++) begin : g_row
      assign wgt_lane[r][k] = wgt_rd[r][k*DATA_WIDTH +: DATA_WIDTH];
      assign prod[r][k]     = inp_lane[k] * wgt_lane[r][k];
    end
  end

  for (genvar c = 0; c < OUTPUT_CHANNEL; c++) begin : g_bias
    assign bias_ch[c] = bias_rd[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    for (int r = 0; r < ARRAY_M; r++) begin
      dot_sum[r] = '0;
      for (int k = 0; k < ARRAY_N; k++) begin
        dot_sum[r] = dot_sum[r] + PE_OUT_WIDTH'(prod[r][k]);
      end
      st_idx[r] = NUM_W'(int'(pass_q) * ARRAY_M + r);
    end
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    win_idx = best_idx_q;
    win_val = best_val_q;
    if ((aidx_q == '0) || (score_q[aidx_q] > best_val_q)) begin
      win_idx = aidx_q;
      win_val = score_q[aidx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      pass_q  <= '0;
      aidx_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pass_q  <= pass_d;
      aidx_q  <= aidx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pass_d    = pass_q;
    aidx_d    = aidx_q;
    busy      = 1'b1;
    done      = 1'b0;
    store_cyc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_d = S_RUN;
          phase_d = '0;
          pass_d  = '0;
        end
      end
      S_RUN: begin
        if (phase_q == PH_W'(BEATS + 1)) begin
          store_cyc = 1'b1;
          phase_d   = '0;
          if (pass_q == PASS_W'(PASSES - 1)) begin
            state_d = S_ARGMAX;
            aidx_d  = '0;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        if (aidx_q == NUM_W'(OUTPUT_CHANNEL - 1)) state_d = S_DONE;
        else aidx_d = aidx_q + 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q      <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
      number_q   <= '0;
      for (int r = 0; r < ARRAY_M; r++) acc_q[r] <= '0;
      for (int c = 0; c < OUTPUT_CHANNEL; c++) score_q[c] <= '0;
    end else begin
      // Read data lags its address by one cycle, so the accumulate enable does too.
      vld_q <= (state_q == S_RUN) && (phase_q < PH_W'(BEATS));
      for (int r = 0; r < ARRAY_M; r++) begin
        if (vld_q) acc_q[r] <= acc_q[r] + dot_sum[r];
        if (store_cyc) begin
          score_q[st_idx[r]] <= acc_q[r] + PE_OUT_WIDTH'(bias_ch[st_idx[r]]);
          acc_q[r]           <= '0;
        end
      end
      if (state_q == S_ARGMAX) begin
        best_val_q <= win_val;
        best_idx_q <= win_idx;
        if (aidx_q == NUM_W'(OUTPUT_CHANNEL - 1)) number_q <= win_idx;
      end
    end
  end

`ifdef FC_SCORE_OUT_EN
  logic signed [PE_OUT_WIDTH-1:0] score_out_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_out_q <= '0;
    end else if ((state_q == S_ARGMAX) && (aidx_q == NUM_W'(OUTPUT_CHANNEL - 1))) begin
      score_out_q <= win_val;
    end
  end

  assign bus.score = score_out_q;
`endif

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.number = number_q;
endmodule

// File: tb/tb_fc_classifier_top.sv
// Self-checking bench for fc_classifier_top: directed spec cases plus randomized data against an integer model.
// Works with or without FC_SCORE_OUT_EN.
module tb_fc_classifier_top;
  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  int m_inp  [96];
  int m_wgt  [10][96];
  int m_bias [10];

  fc_classifier_top_if bus_if ();

  fc_classifier_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_eval(output int win, output int best);
    int s;
    win  = 0;
    best = 0;
    for (int c = 0; c < 10; c++) begin
      s = m_bias[c];
      for (int i = 0; i < 96; i++) s += m_inp[i] * m_wgt[c][i];
      if (c == 0 || s > best) begin
        best = s;
        win  = c;
      end
    end
  endfunction

  function automatic logic [127:0] inp_word(input int b);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(m_inp[16*b + k]);
    return w;
  endfunction

  task automatic load_params();
    logic [127:0] w;
    logic [79:0]  bw;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      for (int b = 0; b < 6; b++) begin
        w = '0;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(m_wgt[c][16*b + k]);
        if (c % 2 == 0) dut.wgt_mem1.mem[(c/2)*6 + b] = w;
        else            dut.wgt_mem2.mem[(c/2)*6 + b] = w;
      end
    end
    bw = '0;
    for (int c = 0; c < 10; c++) bw[8*c +: 8] = 8'(m_bias[c]);
    dut.bias_mem.mem[0] = bw;
  endtask

  task automatic push_inputs();
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      bus_if.we      = 1'b1;
      bus_if.wr_addr = 10'(b);
      bus_if.wr_data = inp_word(b);
    end
    @(negedge clk);
    bus_if.we = 1'b0;
  endtask

  task automatic fill(input int iv, input int wv, input int bv);
    for (int i = 0; i < 96; i++) m_inp[i] = iv;
    for (int c = 0; c < 10; c++) begin
      m_bias[c] = bv;
      for (int i = 0; i < 96; i++) m_wgt[c][i] = wv;
    end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < 96; i++) m_inp[i] = int'($urandom_range(hi - lo)) + lo;
    for (int c = 0; c < 10; c++) begin
      m_bias[c] = int'($urandom_range(hi - lo)) + lo;
      for (int i = 0; i < 96; i++) m_wgt[c][i] = int'($urandom_range(hi - lo)) + lo;
    end
  endtask

  // lat = index of the edge (counted from the start-sampling edge) on which done is sampled high; -1 if never.
  task automatic run_inf(input int again_cyc, input bit wr_busy, input int abort_cyc,
                         output int lat, output logic [3:0] num,
                         output logic signed [23:0] sc, output int busy_err);
    int m;
    lat      = -1;
    busy_err = 0;
    num      = '0;
    sc       = '0;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (m = 0; m < 120; m++) begin
      if (bus_if.done === 1'b1) begin
        lat = m + 1;
        num = bus_if.number;
`ifdef FC_SCORE_OUT_EN
        sc  = bus_if.score;
`endif
        break;
      end
      if (bus_if.busy !== 1'b1) busy_err++;
      bus_if.start = (m == again_cyc);
      if (wr_busy && m >= 5 && m < 11) begin
        bus_if.we      = 1'b1;
        bus_if.wr_addr = 10'(m - 5);
        bus_if.wr_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus_if.we = 1'b0;
      end
      reset_n = (m == abort_cyc) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    bus_if.we    = 1'b0;
    reset_n      = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus_if.start   = 1'b1;
    bus_if.we      = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus_if.number !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_number: got %0d expected 0", bus_if.number);
    end
    tests_run++;
    if (bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    end
    tests_run++;
    if (bus_if.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b expected 0", bus_if.done);
    end
    reset_n      = 1'b1;
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_start_ignored: busy got %b expected 0", bus_if.busy);
    end
  endtask

  task automatic test_basic();
    int lat, be;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill(1, 1, 0);
    for (int c = 0; c < 10; c++) m_bias[c] = c;
    load_params();
    push_inputs();
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (lat !== 51) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 51", lat);
    end
    tests_run++;
    if (num !== 4'd9) begin
      tests_failed++;
      $display("FAIL basic_number: got %0d expected 9", num);
    end
    tests_run++;
    if (be !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy: %0d cycles low, expected 0", be);
    end
`ifdef FC_SCORE_OUT_EN
    tests_run++;
    if (sc !== 24'sd105) begin
      tests_failed++;
      $display("FAIL basic_score: got %0d expected 105", sc);
    end
`endif
    @(negedge clk);
    tests_run++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: done=%b busy=%b expected 0 0", bus_if.done, bus_if.busy);
    end
  endtask

  task automatic test_sign_tie();
    int lat, be;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill(-1, 1, 0);
    load_params();
    push_inputs();
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'd0) begin
      tests_failed++;
      $display("FAIL tie_all_number: got %0d expected 0", num);
    end
`ifdef FC_SCORE_OUT_EN
    tests_run++;
    if (sc !== -24'sd96) begin
      tests_failed++;
      $display("FAIL tie_all_score: got %0d expected -96", sc);
    end
`endif
    m_bias[3] = 5;
    m_bias[7] = 5;
    load_params();
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'd3) begin
      tests_failed++;
      $display("FAIL tie_pair_number: got %0d expected 3", num);
    end
  endtask

  task automatic test_worst();
    int lat, be;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill(-128, -128, 0);
    m_bias[6] = 127;
    load_params();
    push_inputs();
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'd6) begin
      tests_failed++;
      $display("FAIL worst_number: got %0d expected 6", num);
    end
`ifdef FC_SCORE_OUT_EN
    tests_run++;
    if (sc !== 24'sd1572991) begin
      tests_failed++;
      $display("FAIL worst_score: got %0d expected 1572991", sc);
    end
`endif
  endtask

  task automatic test_random();
    int lat, be, ew, es;
    logic [3:0] num;
    logic signed [23:0] sc;
    for (int it = 0; it < 6; it++) begin
      if (it >= 4) fill_random(-1, 1);
      else         fill_random(-128, 127);
      model_eval(ew, es);
      load_params();
      push_inputs();
      run_inf(-1, 1'b0, -1, lat, num, sc, be);
      tests_run++;
      if (num !== 4'(ew) || lat !== 51) begin
        tests_failed++;
        $display("FAIL random_%0d: number %0d lat %0d expected %0d lat 51", it, num, lat, ew);
      end
`ifdef FC_SCORE_OUT_EN
      tests_run++;
      if (sc !== 24'(es)) begin
        tests_failed++;
        $display("FAIL random_score_%0d: got %0d expected %0d", it, sc, es);
      end
`endif
    end
  endtask

  task automatic test_protocol();
    int lat, be, ew, es;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill_random(-128, 127);
    model_eval(ew, es);
    load_params();
    push_inputs();
    run_inf(20, 1'b1, -1, lat, num, sc, be);
    tests_run++;
    if (lat !== 51) begin
      tests_failed++;
      $display("FAIL proto_latency: got %0d expected 51", lat);
    end
    tests_run++;
    if (num !== 4'(ew)) begin
      tests_failed++;
      $display("FAIL proto_number: got %0d expected %0d", num, ew);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_no_restart: busy got %b expected 0", bus_if.busy);
    end
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'(ew)) begin
      tests_failed++;
      $display("FAIL proto_rerun: got %0d expected %0d", num, ew);
    end
  endtask

  task automatic test_abort();
    int lat, be, ew, es;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill_random(-128, 127);
    model_eval(ew, es);
    load_params();
    push_inputs();
    run_inf(-1, 1'b0, 30, lat, num, sc, be);
    tests_run++;
    if (lat !== -1) begin
      tests_failed++;
      $display("FAIL abort_no_done: done seen at edge %0d expected none", lat);
    end
    tests_run++;
    if (bus_if.number !== 4'd0 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: number %0d busy %b expected 0 0", bus_if.number, bus_if.busy);
    end
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'(ew) || lat !== 51) begin
      tests_failed++;
      $display("FAIL abort_recover: number %0d lat %0d expected %0d lat 51", num, lat, ew);
    end
  endtask

  task automatic test_back_to_back();
    int lat, be, ew, es;
    logic [3:0] num;
    logic signed [23:0] sc;
    fill_random(-128, 127);
    model_eval(ew, es);
    load_params();
    push_inputs();
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'(ew)) begin
      tests_failed++;
      $display("FAIL b2b_first: got %0d expected %0d", num, ew);
    end
    // New beat-0 inputs written on the same edge that accepts start must be used.
    for (int i = 0; i < 16; i++) m_inp[i] = int'($urandom_range(255)) - 128;
    model_eval(ew, es);
    @(negedge clk);
    bus_if.we      = 1'b1;
    bus_if.wr_addr = 10'd0;
    bus_if.wr_data = inp_word(0);
    run_inf(-1, 1'b0, -1, lat, num, sc, be);
    tests_run++;
    if (num !== 4'(ew) || lat !== 51) begin
      tests_failed++;
      $display("FAIL b2b_coincident: number %0d lat %0d expected %0d lat 51", num, lat, ew);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_sign_tie();
    test_worst();
    test_random();
    test_protocol();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
